// File: rtl/modexp_if.sv
// Handshake bundle between the modexp sequencer, its launcher and the modular-multiplier datapath.
// The slave modport is the sequencer's view; the master modport is the surrounding datapath/top.
interface modexp_if #(
  parameter int EXP_W = 32,
  parameter int IDX_W = 5
);
  logic             start;
  logic [EXP_W-1:0] exponent;
  logic             busy;
  logic             done;
  logic             mm_start;
  logic             mm_op;
  logic             mm_done;
  logic             acc_init;
  logic             acc_we;
  logic [IDX_W-1:0] bit_index;

  modport slave (
    input  start, exponent, mm_done,
    output busy, done, mm_start, mm_op, acc_init, acc_we, bit_index
  );

  modport master (
    output start, exponent, mm_done,
    input  busy, done, mm_start, mm_op, acc_init, acc_we, bit_index
  );
endinterface

// File: rtl/modexp_sequencer.sv
// Square-and-multiply scheduler: walks the exponent MSB-first, issuing one modular multiply at a time.
// Option MODEXP_SKIP_LEADING_ZEROS_EN adds a SKIP state that steps over leading zero exponent bits.
module modexp_sequencer #(
  parameter int EXP_W = 32,
  parameter int IDX_W = 5
) (
  input  logic     clk,
  input  logic     rst,
  modexp_if.slave  bus
);

`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_SQR_ISSUE, S_SQR_WAIT, S_MUL_ISSUE, S_MUL_WAIT, S_NEXT, S_DONE, S_SKIP
  } state_t;
`else
  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_SQR_ISSUE, S_SQR_WAIT, S_MUL_ISSUE, S_MUL_WAIT, S_NEXT, S_DONE
  } state_t;
`endif

  state_t           state, state_nxt;
  logic [IDX_W-1:0] bit_cnt, cnt_nxt;
  logic [EXP_W-1:0] exp_reg;
  logic [EXP_W-1:0] exp_shr;
  logic             cur_bit;
  logic             load_exp;

  assign exp_shr = exp_reg >> bit_cnt;
  assign cur_bit = exp_shr[0];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    load_exp  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          load_exp  = 1'b1;
          cnt_nxt   = IDX_W'(EXP_W - 1);
          state_nxt = S_INIT;
        end
      end
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
      S_INIT: state_nxt = S_SKIP;
      S_SKIP: begin
        if (bit_cnt != '0 && !cur_bit) cnt_nxt = bit_cnt - IDX_W'(1);
        else                           state_nxt = S_SQR_ISSUE;
      end
`else
      S_INIT: state_nxt = S_SQR_ISSUE;
`endif
      S_SQR_ISSUE: state_nxt = S_SQR_WAIT;
      S_SQR_WAIT: begin
        if (bus.mm_done) state_nxt = cur_bit ? S_MUL_ISSUE : S_NEXT;
      end
      S_MUL_ISSUE: state_nxt = S_MUL_WAIT;
      S_MUL_WAIT: begin
        if (bus.mm_done) state_nxt = S_NEXT;
      end
      S_NEXT: begin
        if (bit_cnt == '0) begin
          state_nxt = S_DONE;
        end else begin
          cnt_nxt   = bit_cnt - IDX_W'(1);
          state_nxt = S_SQR_ISSUE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= cnt_nxt;
    end
  end

  // Exponent is datapath state: captured on accept only, never cleared.
  always_ff @(posedge clk) begin
    if (load_exp) exp_reg <= bus.exponent;
  end

  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DONE);
  assign bus.mm_start  = (state == S_SQR_ISSUE) || (state == S_MUL_ISSUE);
  assign bus.mm_op     = (state == S_MUL_ISSUE) || (state == S_MUL_WAIT);
  assign bus.acc_init  = (state == S_INIT);
  assign bus.bit_index = bit_cnt;
  // Write strobe coincides with mm_done so the accumulator holds the result before the next issue samples it.
  assign bus.acc_we    = ((state == S_SQR_WAIT) || (state == S_MUL_WAIT)) && bus.mm_done;

endmodule

// File: tb/tb_modexp_sequencer.sv
// Scoreboard bench for modexp_sequencer with EXP_W=8 and a fixed-latency (L=3) multiplier model.
module tb_modexp_sequencer;
  localparam int EXP_W = 8;
  localparam int IDX_W = 3;
  localparam int L     = 3;
  localparam int BASE  = 5;
  localparam int MODN  = 1009;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  logic mm_done_model = 1'b0;
  logic mm_done_inj   = 1'b0;

  int acc = 1;
  int res = 1;
  int we_cnt = 0;
  int init_cnt = 0;
  int start_cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  bit exp_op[$];
  int exp_done[$];
  int exp_acc[$];
  int exp_we[$];
  int exp_init[$];

  modexp_if #(.EXP_W(EXP_W), .IDX_W(IDX_W)) bus ();
  assign bus.mm_done = mm_done_model | mm_done_inj;

  modexp_sequencer #(.EXP_W(EXP_W), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int powmod(input logic [7:0] e);
    int r = 1;
    int b = BASE;
    for (int i = 0; i < EXP_W; i++) begin
      if (e[i]) r = (r * b) % MODN;
      b = (b * b) % MODN;
    end
    return r;
  endfunction

  function automatic int outs();
    return int'({bus.busy, bus.done, bus.mm_start, bus.mm_op, bus.acc_init, bus.acc_we, bus.bit_index});
  endfunction

  // Multiplier model: computes on mm_start, answers exactly L cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.mm_start) begin
        res = bus.mm_op ? (acc * BASE) % MODN : (acc * acc) % MODN;
        repeat (L) @(posedge clk);
        #1 mm_done_model = 1'b1;
        @(posedge clk);
        #1 mm_done_model = 1'b0;
      end
    end
  end

  // Monitor: tracks accumulator and pops expectations as the DUT presents events.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.acc_init) begin
        acc = 1;
        init_cnt++;
      end
      if (bus.acc_we) begin
        acc = res;
        we_cnt++;
      end
      if (bus.mm_start) begin
        if (exp_op.size() == 0) check("unexpected_mm_start", int'(bus.mm_start), 0);
        else check("mm_op", int'(bus.mm_op), int'(exp_op.pop_front()));
      end
      if (bus.done) begin
        if (exp_done.size() == 0) begin
          check("unexpected_done", int'(bus.done), 0);
        end else begin
          check("done_cycle", cyc - start_cyc, exp_done.pop_front());
          check("acc_result", acc, exp_acc.pop_front());
          check("acc_we_count", we_cnt, exp_we.pop_front());
          check("acc_init_count", init_cnt, exp_init.pop_front());
        end
      end
    end
  end

  task automatic push_ops(input logic [7:0] e);
    int top = EXP_W - 1;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
    top = 0;
    for (int i = 0; i < EXP_W; i++) if (e[i]) top = i;
`endif
    for (int i = top; i >= 0; i--) begin
      exp_op.push_back(1'b0);
      if (e[i]) exp_op.push_back(1'b1);
    end
  endtask

  task automatic run(input logic [7:0] e, input int done_c, input int n_we,
                     input bit inj, input bit repulse);
    bit got = 1'b0;
    @(posedge clk);
    #1;
    push_ops(e);
    exp_done.push_back(done_c);
    exp_acc.push_back(powmod(e));
    exp_we.push_back(we_cnt + n_we);
    exp_init.push_back(init_cnt + 1);
    start_cyc    = cyc;
    bus.exponent = e;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.exponent = ~e;
    if (inj) begin
      mm_done_inj = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 mm_done_inj = 1'b0;
    end
    if (repulse) begin
      while (cyc - start_cyc < 10) begin
        @(posedge clk);
        #1;
      end
      check("cyc10_busy", int'(bus.busy), 1);
      check("cyc10_bit_index", int'(bus.bit_index), 7);
      bus.start    = 1'b1;
      bus.exponent = 8'h00;
      @(posedge clk);
      #1 bus.start = 1'b0;
    end
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("done_timeout", int'(bus.done), 1);
    if (repulse) begin
      bus.start    = 1'b1;
      bus.exponent = 8'h0F;
      @(posedge clk);
      #1 bus.start = 1'b0;
      check("done_repulse_busy", int'(bus.busy), 0);
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int base_we;
    bus.start    = 1'b0;
    bus.exponent = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", outs(), 0);
    rst = 1'b0;

`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
    run(8'hB1, 59, 12, 1'b0, 1'b0);
    run(8'h00, 15, 1, 1'b0, 1'b0);
    run(8'hFF, 75, 16, 1'b0, 1'b1);
    run(8'hB1, 59, 12, 1'b1, 1'b0);
`else
    run(8'hB1, 58, 12, 1'b0, 1'b0);
    run(8'h00, 42, 8, 1'b0, 1'b0);
    run(8'hFF, 74, 16, 1'b0, 1'b1);
    run(8'hB1, 58, 12, 1'b1, 1'b0);
`endif

    // Abort an 8'hB1 run at cycle 20.
    @(posedge clk);
    #1;
    push_ops(8'hB1);
    start_cyc    = cyc;
    bus.exponent = 8'hB1;
    bus.start    = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    while (cyc - start_cyc < 20) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_outputs", outs(), 0);
    rst = 1'b0;
    exp_op.delete();
    base_we = we_cnt;
    repeat (8) @(posedge clk);
    #1;
    check("abort_idle_busy", int'(bus.busy), 0);
    check("abort_no_acc_we", we_cnt, base_we);

`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
    run(8'h03, 27, 4, 1'b0, 1'b0);
    run(8'h05, 31, 5, 1'b0, 1'b0);
`else
    run(8'h03, 50, 10, 1'b0, 1'b0);
    run(8'h05, 50, 10, 1'b0, 1'b0);
`endif

    check("ops_left", exp_op.size(), 0);
    check("done_left", exp_done.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
